// File: rtl/memoria_instrucciones_param.sv
// Parametrised instruction memory for the fetch stage: synchronous read with 1-cycle latency,
// stall/flush on the output register, a program-load write port and a post-reset clear sweep.
module memoria_instrucciones_param #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 10,
  parameter int                 DEPTH    = 1024,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] direccion,
  input  logic              leer,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instruccion,
  output logic              valida,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              listo
);

  // Index width of the implemented array; DEPTH never exceeds 2**ADDR_W so this slice is safe.
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [DATA_W-1:0] instr_reg;
  logic              valida_reg;
  logic              listo_reg;

  logic              rd_in_range;
  logic              wr_in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IDX_W-1:0]  rd_idx;
  logic              bypass;

  assign rd_in_range = {1'b0, direccion} < DEPTH_C;
  assign wr_in_range = {1'b0, waddr} < DEPTH_C;
  assign rd_idx      = direccion[IDX_W-1:0];
  // Same-cycle write to the fetched address forwards the new word (write-first).
  assign bypass      = we && wr_in_range && (waddr == direccion);

  // The single write port is shared between the clear sweep and program loading.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr[IDX_W-1:0];
    mem_wdata = wdata;
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg[IDX_W-1:0];
      mem_wdata = NOP_WORD;
    end else if (we && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= CLEAR;
      cnt_reg    <= '0;
      instr_reg  <= NOP_WORD;
      valida_reg <= 1'b0;
      listo_reg  <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          instr_reg  <= NOP_WORD;
          valida_reg <= 1'b0;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= RUN;
            listo_reg <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            instr_reg  <= NOP_WORD;
            valida_reg <= 1'b0;
          end else if (stall) begin
            instr_reg  <= instr_reg;
            valida_reg <= valida_reg;
          end else if (leer) begin
            // An out-of-range fetch is a legal halt: NOP word, still marked valid.
            valida_reg <= 1'b1;
            if (!rd_in_range) begin
              instr_reg <= NOP_WORD;
            end else if (bypass) begin
              instr_reg <= wdata;
            end else begin
              instr_reg <= mem[rd_idx];
            end
          end else begin
            instr_reg  <= NOP_WORD;
            valida_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign instruccion = instr_reg;
  assign valida      = valida_reg;
  assign listo       = listo_reg;

endmodule

// File: tb/tb_memoria_instrucciones_param.sv
// Directed bench for memoria_instrucciones_param: a 1024-word default instance and an
// 8-word instance with a 4-bit address, checked through an expected-result queue.
module tb_memoria_instrucciones_param;

  logic        clk = 1'b0;
  logic        reset;

  logic [9:0]  direccion, waddr;
  logic        leer, stall, flush, we;
  logic [31:0] wdata;
  logic [31:0] instruccion;
  logic        valida, listo;

  logic [3:0]  s_direccion, s_waddr;
  logic        s_leer, s_stall, s_flush, s_we;
  logic [31:0] s_wdata;
  logic [31:0] s_instruccion;
  logic        s_valida, s_listo;

  typedef struct packed {
    logic [31:0] d;
    logic        v;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  memoria_instrucciones_param dut (
    .clk(clk), .reset(reset), .direccion(direccion), .leer(leer), .stall(stall),
    .flush(flush), .instruccion(instruccion), .valida(valida), .we(we),
    .waddr(waddr), .wdata(wdata), .listo(listo)
  );

  memoria_instrucciones_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(8)) dut_s (
    .clk(clk), .reset(reset), .direccion(s_direccion), .leer(s_leer), .stall(s_stall),
    .flush(s_flush), .instruccion(s_instruccion), .valida(s_valida), .we(s_we),
    .waddr(s_waddr), .wdata(s_wdata), .listo(s_listo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      $display("txn %s: instruccion=%h valida=%0b", t, instruccion, valida);
      chk({t, "_data"}, instruccion, e.d);
      chk({t, "_valida"}, {31'd0, valida}, {31'd0, e.v});
    end
  endtask

  // Drive one fetch, advance one clock and compare against the queued expectation.
  task automatic fetch(input string tag, input logic [9:0] a, input logic [31:0] d, input logic v);
    direccion = a;
    expect_out(tag, d, v);
    tick();
    pop_check();
  endtask

  initial begin
    int k, s_k;
    logic bad_valid;

    reset = 1'b1;
    direccion = '0; leer = 0; stall = 0; flush = 0; we = 0; waddr = '0; wdata = '0;
    s_direccion = '0; s_leer = 0; s_stall = 0; s_flush = 0; s_we = 0; s_waddr = '0; s_wdata = '0;
    tick();
    tick();
    chk("reset_instr", instruccion, 32'h0);
    chk("reset_valida", {31'd0, valida}, 32'd0);
    chk("reset_listo", {31'd0, listo}, 32'd0);

    // Clear sweep: writes and fetches must be ignored while it runs.
    reset = 1'b0;
    we = 1; waddr = 10'd3; wdata = 32'hFFFF_FFFF; leer = 1; direccion = 10'd3;
    k = 0; s_k = 0; bad_valid = 1'b0;
    while (!listo && k < 3000) begin
      tick();
      k++;
      if (s_listo && s_k == 0) s_k = k;
      if (valida) bad_valid = 1'b1;
    end
    we = 0;
    $display("txn clear: listo after %0d cycles, small after %0d", k, s_k);
    chk("clear_cycles", k, 1024);
    chk("clear_cycles_small", s_k, 8);
    chk("clear_valida_low", {31'd0, bad_valid}, 32'd0);

    fetch("cleared_addr3", 10'd3, 32'h0, 1'b1);
    fetch("cleared_addr700", 10'd700, 32'h0, 1'b1);

    // Program load then back-to-back fetch.
    leer = 0;
    we = 1; waddr = 10'd0; wdata = 32'h0064_1020;
    expect_out("load0", 32'h0, 1'b0);
    tick(); pop_check();
    waddr = 10'd1; wdata = 32'h2062_0010;
    expect_out("load1", 32'h0, 1'b0);
    tick(); pop_check();
    we = 0; leer = 1;
    fetch("fetch0", 10'd0, 32'h0064_1020, 1'b1);
    fetch("fetch1", 10'd1, 32'h2062_0010, 1'b1);

    // Plain stall for three cycles while the address moves.
    stall = 1;
    fetch("stall1", 10'd0, 32'h2062_0010, 1'b1);
    fetch("stall2", 10'd2, 32'h2062_0010, 1'b1);
    fetch("stall3", 10'd3, 32'h2062_0010, 1'b1);
    stall = 0;

    // Stall again with a flush on the second cycle; flush wins and the bubble is then held.
    fetch("refetch1", 10'd1, 32'h2062_0010, 1'b1);
    stall = 1;
    fetch("sf_stall1", 10'd0, 32'h2062_0010, 1'b1);
    flush = 1;
    fetch("sf_flush", 10'd0, 32'h0, 1'b0);
    flush = 0;
    fetch("sf_stall3", 10'd1, 32'h0, 1'b0);
    stall = 0;

    // No fetch request gives a bubble.
    fetch("refetch0", 10'd0, 32'h0064_1020, 1'b1);
    leer = 0;
    fetch("no_leer", 10'd0, 32'h0, 1'b0);
    leer = 1;

    // Same-cycle write and read of address 5 returns the new word.
    we = 1; waddr = 10'd5; wdata = 32'h8C01_0001;
    fetch("write_first", 10'd5, 32'h8C01_0001, 1'b1);
    we = 0;
    fetch("readback5", 10'd5, 32'h8C01_0001, 1'b1);

    // Writes are not blocked by stall.
    stall = 1; we = 1; waddr = 10'd6; wdata = 32'h1234_5678;
    fetch("stall_write", 10'd6, 32'h8C01_0001, 1'b1);
    stall = 0; we = 0;
    fetch("readback6", 10'd6, 32'h1234_5678, 1'b1);
    leer = 0;

    // Small instance: fill 0..7, write out of range, then read all plus address 12.
    s_we = 1;
    for (int i = 0; i < 8; i++) begin
      s_waddr = 4'(i);
      s_wdata = 32'hA0 + 32'(i);
      tick();
    end
    s_waddr = 4'd12; s_wdata = 32'hDEAD_BEEF;
    tick();
    s_we = 0; s_leer = 1;
    for (int i = 0; i < 8; i++) begin
      s_direccion = 4'(i);
      tick();
      $display("txn small_read %0d: instruccion=%h valida=%0b", i, s_instruccion, s_valida);
      chk($sformatf("small_read%0d", i), s_instruccion, 32'hA0 + 32'(i));
      chk($sformatf("small_valida%0d", i), {31'd0, s_valida}, 32'd1);
    end
    s_direccion = 4'd12;
    tick();
    $display("txn small_oor: instruccion=%h valida=%0b", s_instruccion, s_valida);
    chk("small_oor_data", s_instruccion, 32'h0);
    chk("small_oor_valida", {31'd0, s_valida}, 32'd1);
    s_leer = 0;

    // One-cycle reset mid-run wipes the loaded program.
    reset = 1;
    tick();
    reset = 0;
    chk("midreset_listo", {31'd0, listo}, 32'd0);
    chk("midreset_valida", {31'd0, valida}, 32'd0);
    k = 0;
    while (!listo && k < 3000) begin
      tick();
      k++;
    end
    $display("txn reclear: listo after %0d cycles", k);
    chk("reclear_cycles", k, 1024);
    leer = 1;
    fetch("after_reclear0", 10'd0, 32'h0, 1'b1);
    fetch("after_reclear5", 10'd5, 32'h0, 1'b1);
    leer = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
